// File: rtl/spi_pkg.sv
// spi_pkg
//   Constants and types shared between the SPI trace frame buffer and the
//   SPI trace transmitter. A frame is WORDS_PER_FRAME words of WORD_W bits.
//   Ports: none (package).
package spi_pkg;

  localparam int WORDS_PER_FRAME = 8;
  localparam int WORD_W          = 16;
  localparam int FRAME_IDX_W     = $clog2(WORDS_PER_FRAME);

  typedef logic [WORD_W-1:0]      word_t;
  typedef logic [FRAME_IDX_W-1:0] frame_idx_t;

  // True when a word index points at the final word of a frame.
  function automatic logic is_last_word(input frame_idx_t idx);
    return idx == frame_idx_t'(WORDS_PER_FRAME - 1);
  endfunction

endpackage

// File: rtl/spi_frame_buffer_frame_ram.sv
// frame_ram
//   Simple dual-port RAM: one synchronous write port, one registered read
//   port. Read-first on an address collision, so a word written at the read
//   address appears on rdata one clock later. No reset on the array or the
//   read register, which keeps it mappable onto block RAM.
//   Ports:
//     clk    - clock
//     we     - write enable
//     waddr  - write address
//     wdata  - write data
//     raddr  - read address (sampled every clock)
//     rdata  - registered read data
module frame_ram #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_frame_buffer.sv
// spi_frame_buffer
//   Frame-granular word buffer in front of the SPI trace transmitter.
//   Words from the capture path are stored in a circular RAM and only become
//   visible to the transmitter once a whole 8-word frame has been written.
//   The transmitter steps through a frame with rising edges of tx_free and
//   can rewind to the start of the in-flight frame with a rising edge of
//   rxFrameReset. Storage is returned only when a frame completes.
//
//   Handshakes: a word is accepted on any clock where wvalid && wready;
//   wready depends only on registered state, never on wvalid. A word offered
//   while wready is low is dropped and counted. tx_free / rxFrameReset are
//   levels whose rising edges are events; they are already synchronous.
//
//   Ports:
//     clk          - clock
//     rst          - asynchronous reset, active low
//     wdata/wvalid - trace word input;  wready - space for one more word
//     flush        - synchronous clear of contents and counters
//     tx_word      - word at the read pointer (0 while nothing is stored)
//     transmitIn   - at least one complete frame is waiting
//     tx_free      - rising edge: current word consumed
//     rxFrameReset - rising edge: rewind to the start of the in-flight frame
//     fill_words   - words stored (committed frames plus partial frame)
//     overflow     - sticky: a word was offered while full
//     drop_count   - saturating count of refused words
module spi_frame_buffer
  import spi_pkg::*;
#(
  parameter  int DEPTH_FRAMES = 4,
  localparam int DEPTH        = DEPTH_FRAMES * WORDS_PER_FRAME,
  localparam int AW           = $clog2(DEPTH),
  localparam int FW           = $clog2(DEPTH) + 1,
  localparam int FAW          = $clog2(DEPTH_FRAMES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  input  logic              flush,
  output logic [WORD_W-1:0] tx_word,
  output logic              transmitIn,
  input  logic              tx_free,
  input  logic              rxFrameReset,
  output logic [FW-1:0]     fill_words,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [AW-1:0]  fsp;
  frame_idx_t     wi;
  frame_idx_t     ri;
  logic [FAW-1:0] frames_avail;
  logic           tx_free_q;
  logic           rx_reset_q;
  logic           data_ok;
  word_t          ram_rdata;

  logic wr_en;
  logic wr_done;
  logic tx_rise;
  logic rx_rise;
  logic rd_step;
  logic rd_done;

  assign wready     = fill_words < FW'(DEPTH);
  assign wr_en      = wvalid && wready;
  assign wr_done    = wr_en && is_last_word(wi);
  assign tx_rise    = tx_free && !tx_free_q;
  assign rx_rise    = rxFrameReset && !rx_reset_q;
  // A rewind in the same cycle swallows the advance; with no committed
  // frame the advance is ignored altogether.
  assign rd_step    = tx_rise && !rx_rise && (frames_avail != '0);
  assign rd_done    = rd_step && is_last_word(ri);
  assign transmitIn = frames_avail != '0;
  // The RAM read register has no reset; data_ok masks it until the RAM
  // holds something meaningful at rp.
  assign tx_word    = data_ok ? ram_rdata : '0;

  frame_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_frame_ram (
    .clk   (clk),
    .we    (wr_en && !flush),
    .waddr (wp),
    .wdata (wdata),
    .raddr (rp),
    .rdata (ram_rdata)
  );

  // Edge-detect stages keep tracking the inputs through a flush so that a
  // level still high afterwards is not mistaken for a new edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_free_q  <= 1'b0;
      rx_reset_q <= 1'b0;
    end else begin
      tx_free_q  <= tx_free;
      rx_reset_q <= rxFrameReset;
    end
  end

  // Write side: pointer and index into the frame being filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      wi <= '0;
    end else if (flush) begin
      wp <= '0;
      wi <= '0;
    end else if (wr_en) begin
      wp <= wp + AW'(1);
      wi <= wi + frame_idx_t'(1);
    end
  end

  // Read side: read pointer, index within the frame, and the frame start
  // that a rewind returns to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp  <= '0;
      ri  <= '0;
      fsp <= '0;
    end else if (flush) begin
      rp  <= '0;
      ri  <= '0;
      fsp <= '0;
    end else if (rx_rise) begin
      rp <= fsp;
      ri <= '0;
    end else if (rd_step) begin
      rp <= rp + AW'(1);
      ri <= ri + frame_idx_t'(1);
      if (rd_done) begin
        fsp <= rp + AW'(1);
      end
    end
  end

  // Occupancy. Write and read completions in the same cycle net out, so
  // both counters are updated arithmetically rather than by priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_avail <= '0;
      fill_words   <= '0;
      data_ok      <= 1'b0;
    end else if (flush) begin
      frames_avail <= '0;
      fill_words   <= '0;
      data_ok      <= 1'b0;
    end else begin
      frames_avail <= frames_avail + FAW'(wr_done) - FAW'(rd_done);
      fill_words   <= fill_words + FW'(wr_en)
                      - (rd_done ? FW'(WORDS_PER_FRAME) : FW'(0));
      data_ok      <= fill_words != '0;
    end
  end

  // Refused-word accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (wvalid && !wready) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Self-checking bench for spi_frame_buffer (DEPTH_FRAMES = 4, 32 words).
// Inputs change on the falling edge; outputs are checked on falling edges.
module tb_spi_frame_buffer;

  logic        clk;
  logic        rst;
  logic [15:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        flush;
  logic [15:0] tx_word;
  logic        transmitIn;
  logic        tx_free;
  logic        rxFrameReset;
  logic [5:0]  fill_words;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks;
  int n_fail;

  spi_frame_buffer #(.DEPTH_FRAMES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wdata        (wdata),
    .wvalid       (wvalid),
    .wready       (wready),
    .flush        (flush),
    .tx_word      (tx_word),
    .transmitIn   (transmitIn),
    .tx_free      (tx_free),
    .rxFrameReset (rxFrameReset),
    .fill_words   (fill_words),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; wvalid = 1'b0; wdata = '0; flush = 1'b0;
    tx_free = 1'b0; rxFrameReset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic write_word(input logic [15:0] d);
    @(negedge clk);
    wvalid = 1'b1; wdata = d;
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic write_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++) write_word(base + 16'(i));
  endtask

  // Returns when the word after the advance is on tx_word.
  task automatic pulse_tx();
    @(negedge clk);
    tx_free = 1'b1;
    @(negedge clk);
    tx_free = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_rx();
    @(negedge clk);
    rxFrameReset = 1'b1;
    @(negedge clk);
    rxFrameReset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; wvalid = 1'b0; wdata = '0; flush = 1'b0;
    tx_free = 1'b0; rxFrameReset = 1'b0;
    @(negedge clk);
    n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL reset_wready: got %b expected 1", wready); end
    n_checks++; if (transmitIn !== 1'b0) begin n_fail++; $display("FAIL reset_transmitIn: got %b expected 0", transmitIn); end
    n_checks++; if (tx_word !== 16'h0000) begin n_fail++; $display("FAIL reset_tx_word: got %h expected 0000", tx_word); end
    n_checks++; if (fill_words !== 6'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_words); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    do_reset();
    for (int i = 0; i < 7; i++) write_word(16'h0001 + 16'(i));
    n_checks++; if (transmitIn !== 1'b0) begin n_fail++; $display("FAIL basic_partial_tin: got %b expected 0", transmitIn); end
    write_word(16'h0008);
    // Checked one clock after the 8th write.
    n_checks++; if (transmitIn !== 1'b1) begin n_fail++; $display("FAIL basic_tin: got %b expected 1", transmitIn); end
    n_checks++; if (fill_words !== 6'd8) begin n_fail++; $display("FAIL basic_fill: got %0d expected 8", fill_words); end
    n_checks++; if (tx_word !== 16'h0001) begin n_fail++; $display("FAIL basic_first_word: got %h expected 0001", tx_word); end
    for (int k = 1; k < 8; k++) begin
      pulse_tx();
      n_checks++; if (tx_word !== 16'h0001 + 16'(k)) begin n_fail++; $display("FAIL basic_word%0d: got %h expected %h", k, tx_word, 16'h0001 + 16'(k)); end
    end
    n_checks++; if (transmitIn !== 1'b1) begin n_fail++; $display("FAIL basic_tin_before_last: got %b expected 1", transmitIn); end
    pulse_tx();
    n_checks++; if (transmitIn !== 1'b0) begin n_fail++; $display("FAIL basic_tin_end: got %b expected 0", transmitIn); end
    n_checks++; if (fill_words !== 6'd0) begin n_fail++; $display("FAIL basic_fill_end: got %0d expected 0", fill_words); end
  endtask

  task automatic test_partial_frame();
    do_reset();
    for (int i = 0; i < 7; i++) write_word(16'h0010 + 16'(i));
    n_checks++; if (transmitIn !== 1'b0) begin n_fail++; $display("FAIL partial_tin: got %b expected 0", transmitIn); end
    n_checks++; if (fill_words !== 6'd7) begin n_fail++; $display("FAIL partial_fill: got %0d expected 7", fill_words); end
    n_checks++; if (tx_word !== 16'h0010) begin n_fail++; $display("FAIL partial_word: got %h expected 0010", tx_word); end
    // No committed frame: the advance must be ignored.
    pulse_tx();
    n_checks++; if (tx_word !== 16'h0010) begin n_fail++; $display("FAIL partial_ignored_tx: got %h expected 0010", tx_word); end
    write_word(16'h0017);
    n_checks++; if (transmitIn !== 1'b1) begin n_fail++; $display("FAIL partial_tin_commit: got %b expected 1", transmitIn); end
    n_checks++; if (fill_words !== 6'd8) begin n_fail++; $display("FAIL partial_fill_commit: got %0d expected 8", fill_words); end
    pulse_tx();
    n_checks++; if (tx_word !== 16'h0011) begin n_fail++; $display("FAIL partial_after_commit: got %h expected 0011", tx_word); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 32; i++) write_word(16'h0100 + 16'(i));
    n_checks++; if (wready !== 1'b0) begin n_fail++; $display("FAIL ovf_wready_full: got %b expected 0", wready); end
    n_checks++; if (fill_words !== 6'd32) begin n_fail++; $display("FAIL ovf_fill_full: got %0d expected 32", fill_words); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
    write_word(16'hDEAD);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL ovf_drop1: got %0d expected 1", drop_count); end
    n_checks++; if (fill_words !== 6'd32) begin n_fail++; $display("FAIL ovf_fill_kept: got %0d expected 32", fill_words); end
    // 1 + 260 refusals saturates at 255.
    @(negedge clk);
    wvalid = 1'b1; wdata = 16'hBEEF;
    repeat (260) @(negedge clk);
    wvalid = 1'b0;
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL ovf_drop_sat: got %0d expected 255", drop_count); end
    n_checks++; if (tx_word !== 16'h0100) begin n_fail++; $display("FAIL ovf_first_word: got %h expected 0100", tx_word); end
    for (int k = 0; k < 8; k++) pulse_tx();
    n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL ovf_wready_drained: got %b expected 1", wready); end
    n_checks++; if (fill_words !== 6'd24) begin n_fail++; $display("FAIL ovf_fill_drained: got %0d expected 24", fill_words); end
    n_checks++; if (tx_word !== 16'h0108) begin n_fail++; $display("FAIL ovf_next_frame: got %h expected 0108", tx_word); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_rewind();
    do_reset();
    write_frame(16'h0A00);
    write_frame(16'h0B00);
    for (int k = 0; k < 5; k++) pulse_tx();
    n_checks++; if (tx_word !== 16'h0A05) begin n_fail++; $display("FAIL rew_pre: got %h expected 0A05", tx_word); end
    pulse_rx();
    n_checks++; if (tx_word !== 16'h0A00) begin n_fail++; $display("FAIL rew_word0: got %h expected 0A00", tx_word); end
    n_checks++; if (fill_words !== 6'd16) begin n_fail++; $display("FAIL rew_fill: got %0d expected 16", fill_words); end
    for (int k = 0; k < 3; k++) pulse_tx();
    // Simultaneous advance and rewind: rewind wins.
    @(negedge clk);
    tx_free = 1'b1; rxFrameReset = 1'b1;
    @(negedge clk);
    tx_free = 1'b0; rxFrameReset = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_word !== 16'h0A00) begin n_fail++; $display("FAIL rew_both_edges: got %h expected 0A00", tx_word); end
    for (int k = 1; k < 8; k++) pulse_tx();
    n_checks++; if (tx_word !== 16'h0A07) begin n_fail++; $display("FAIL rew_word7: got %h expected 0A07", tx_word); end
    pulse_tx();
    n_checks++; if (tx_word !== 16'h0B00) begin n_fail++; $display("FAIL rew_next_frame: got %h expected 0B00", tx_word); end
    n_checks++; if (fill_words !== 6'd8) begin n_fail++; $display("FAIL rew_fill_done: got %0d expected 8", fill_words); end
    n_checks++; if (transmitIn !== 1'b1) begin n_fail++; $display("FAIL rew_tin_one_left: got %b expected 1", transmitIn); end
    for (int k = 0; k < 8; k++) pulse_tx();
    n_checks++; if (transmitIn !== 1'b0) begin n_fail++; $display("FAIL rew_tin_end: got %b expected 0", transmitIn); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_frame(16'h0C00);
    for (int i = 0; i < 7; i++) write_word(16'h0D00 + 16'(i));
    for (int k = 0; k < 7; k++) pulse_tx();
    n_checks++; if (tx_word !== 16'h0C07) begin n_fail++; $display("FAIL b2b_pre: got %h expected 0C07", tx_word); end
    // Frame 2 completes on the same clock frame 1 is consumed.
    @(negedge clk);
    wvalid = 1'b1; wdata = 16'h0D07; tx_free = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; tx_free = 1'b0;
    n_checks++; if (transmitIn !== 1'b1) begin n_fail++; $display("FAIL b2b_tin: got %b expected 1", transmitIn); end
    n_checks++; if (fill_words !== 6'd8) begin n_fail++; $display("FAIL b2b_fill: got %0d expected 8", fill_words); end
    @(negedge clk);
    n_checks++; if (tx_word !== 16'h0D00) begin n_fail++; $display("FAIL b2b_word0: got %h expected 0D00", tx_word); end
    for (int k = 1; k < 8; k++) begin
      pulse_tx();
      n_checks++; if (tx_word !== 16'h0D00 + 16'(k)) begin n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", k, tx_word, 16'h0D00 + 16'(k)); end
    end
    pulse_tx();
    n_checks++; if (transmitIn !== 1'b0) begin n_fail++; $display("FAIL b2b_tin_end: got %b expected 0", transmitIn); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 35; i++) write_word(16'h0200 + 16'(i));
    pulse_tx();
    pulse_tx();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL flush_pre_ovf: got %b expected 1", overflow); end
    // Flush together with an offered word: flush wins, word is not stored.
    @(negedge clk);
    flush = 1'b1; wvalid = 1'b1; wdata = 16'h7777;
    @(negedge clk);
    flush = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (fill_words !== 6'd0) begin n_fail++; $display("FAIL flush_fill: got %0d expected 0", fill_words); end
    n_checks++; if (transmitIn !== 1'b0) begin n_fail++; $display("FAIL flush_tin: got %b expected 0", transmitIn); end
    n_checks++; if (tx_word !== 16'h0000) begin n_fail++; $display("FAIL flush_tx_word: got %h expected 0000", tx_word); end
    n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL flush_wready: got %b expected 1", wready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b expected 0", overflow); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL flush_drop: got %0d expected 0", drop_count); end
    write_frame(16'h0F00);
    n_checks++; if (transmitIn !== 1'b1) begin n_fail++; $display("FAIL flush_next_tin: got %b expected 1", transmitIn); end
    n_checks++; if (tx_word !== 16'h0F00) begin n_fail++; $display("FAIL flush_next_word0: got %h expected 0F00", tx_word); end
    for (int k = 1; k < 8; k++) begin
      pulse_tx();
      n_checks++; if (tx_word !== 16'h0F00 + 16'(k)) begin n_fail++; $display("FAIL flush_next_word%0d: got %h expected %h", k, tx_word, 16'h0F00 + 16'(k)); end
    end
    pulse_tx();
    n_checks++; if (fill_words !== 6'd0) begin n_fail++; $display("FAIL flush_next_fill_end: got %0d expected 0", fill_words); end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_frame(16'h0300);
    for (int i = 0; i < 4; i++) write_word(16'h0308 + 16'(i));
    pulse_tx();
    pulse_tx();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (fill_words !== 6'd0) begin n_fail++; $display("FAIL arst_fill: got %0d expected 0", fill_words); end
    n_checks++; if (transmitIn !== 1'b0) begin n_fail++; $display("FAIL arst_tin: got %b expected 0", transmitIn); end
    n_checks++; if (tx_word !== 16'h0000) begin n_fail++; $display("FAIL arst_tx_word: got %h expected 0000", tx_word); end
    n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL arst_wready: got %b expected 1", wready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    write_frame(16'h0E00);
    n_checks++; if (fill_words !== 6'd8) begin n_fail++; $display("FAIL arst_next_fill: got %0d expected 8", fill_words); end
    n_checks++; if (tx_word !== 16'h0E00) begin n_fail++; $display("FAIL arst_next_word0: got %h expected 0E00", tx_word); end
    for (int k = 1; k < 8; k++) pulse_tx();
    n_checks++; if (tx_word !== 16'h0E07) begin n_fail++; $display("FAIL arst_next_word7: got %h expected 0E07", tx_word); end
    pulse_tx();
    n_checks++; if (transmitIn !== 1'b0) begin n_fail++; $display("FAIL arst_next_tin_end: got %b expected 0", transmitIn); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; wvalid = 1'b0; wdata = '0; flush = 1'b0;
    tx_free = 1'b0; rxFrameReset = 1'b0;
    test_reset();
    test_basic_frame();
    test_partial_frame();
    test_overflow();
    test_rewind();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
